// File: rtl/exp6_detector_jogada.sv
// rtl/exp6_detector_jogada.sv - button synchronizer, whole-vector debouncer and play-detect FSM.
// Optional REJEITA_MULTIPLO_EN: reject multi-button presses instead of resolving by lowest index.
module exp6_detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] botoes,
  input  logic       habilita,
  input  logic       limpa,
  output logic       tem_jogada,
  output logic [3:0] jogada,
  output logic       multiplo,
  output logic [1:0] db_estado
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    ACEITA    = 2'd1,
    SEGURA    = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  logic [3:0]    sync_a;
  logic [3:0]    s;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic [3:0]    estavel;
  estado_t       estado;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 4'b0000;
      s      <= 4'b0000;
    end else begin
      sync_a <= botoes;
      s      <= sync_a;
    end
  end

  // The whole vector must hold for DEBOUNCE_CYCLES cycles; any bit change restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand    <= 4'b0000;
      cnt     <= '0;
      estavel <= 4'b0000;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      estavel <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  logic [3:0] menor;
  assign menor = estavel & (~estavel + 4'd1);

`ifdef REJEITA_MULTIPLO_EN
  logic varios;
  assign varios = |(estavel & (estavel - 4'd1));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= LIVRE;
      tem_jogada <= 1'b0;
      multiplo   <= 1'b0;
      jogada     <= 4'b0000;
    end else begin
      tem_jogada <= 1'b0;
      multiplo   <= 1'b0;
      if (limpa) begin
        jogada <= 4'b0000;
      end
      case (estado)
        LIVRE: begin
          if (estavel != 4'b0000) begin
`ifdef REJEITA_MULTIPLO_EN
            if (varios) begin
              estado   <= BLOQUEADO;
              multiplo <= 1'b1;
            end else if (habilita) begin
              estado     <= ACEITA;
              tem_jogada <= 1'b1;
              jogada     <= estavel;
            end else begin
              estado <= BLOQUEADO;
            end
`else
            // Multi-press collapses to the lowest-index button.
            if (habilita) begin
              estado     <= ACEITA;
              tem_jogada <= 1'b1;
              jogada     <= menor;
            end else begin
              estado <= BLOQUEADO;
            end
`endif
          end
        end
        ACEITA: begin
          estado <= SEGURA;
        end
        SEGURA, BLOQUEADO: begin
          if (estavel == 4'b0000) begin
            estado <= LIVRE;
          end
        end
        default: estado <= LIVRE;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp6_detector_jogada.sv
// tb/tb_exp6_detector_jogada.sv - directed self-checking bench for exp6_detector_jogada with DEBOUNCE_CYCLES=4.
module tb_exp6_detector_jogada;

  localparam int D = 4;
  // Edges from an input change (driven just after an edge) to the reaction: 1 sampling edge + D + 3.
  localparam int LAT = D + 4;

  logic       clock;
  logic       reset_n;
  logic [3:0] botoes;
  logic       habilita;
  logic       limpa;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic       multiplo;
  logic [1:0] db_estado;

  int checks;
  int fails;

  exp6_detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .botoes     (botoes),
    .habilita   (habilita),
    .limpa      (limpa),
    .tem_jogada (tem_jogada),
    .jogada     (jogada),
    .multiplo   (multiplo),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = 0;
    while (n < max) begin
      tick(1);
      n++;
      if (tem_jogada === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic wait_estado(input logic [1:0] st, input int max, output int n);
    n = 0;
    while (n < max) begin
      tick(1);
      n++;
      if (db_estado === st) return;
    end
    n = -1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; botoes = 4'b0000; habilita = 1'b0; limpa = 1'b0;
    tick(3);
    checks++;
    if ({tem_jogada, jogada, multiplo, db_estado} !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs got tem=%b jogada=%b mult=%b est=%0d expected all zero",
               tem_jogada, jogada, multiplo, db_estado);
    end
    reset_n = 1'b1;
    tick(2);
    checks++;
    if (db_estado !== 2'd0) begin
      fails++;
      $display("FAIL reset_idle got est=%0d expected 0", db_estado);
    end
  endtask

  task automatic test_clean_press;
    int n;
    int pulses;
    habilita = 1'b1;
    botoes = 4'b0100;
    wait_strobe(20, n);
    checks++;
    if (n !== LAT) begin
      fails++;
      $display("FAIL clean_latency got %0d edges expected %0d", n, LAT);
    end
    checks++;
    if (jogada !== 4'b0100 || db_estado !== 2'd1) begin
      fails++;
      $display("FAIL clean_accept got jogada=%b est=%0d expected 0100 est=1", jogada, db_estado);
    end
    tick(1);
    checks++;
    if (tem_jogada !== 1'b0 || db_estado !== 2'd2) begin
      fails++;
      $display("FAIL clean_segura got tem=%b est=%0d expected tem=0 est=2", tem_jogada, db_estado);
    end
    pulses = 0;
    for (int i = 0; i < 20 - n - 1; i++) begin
      tick(1);
      if (tem_jogada === 1'b1) pulses++;
    end
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
    checks++;
    if (pulses !== 0 || n !== LAT) begin
      fails++;
      $display("FAIL clean_release got extra=%0d livre_after=%0d expected 0 and %0d", pulses, n, LAT);
    end
    checks++;
    if (jogada !== 4'b0100) begin
      fails++;
      $display("FAIL clean_hold got jogada=%b expected 0100", jogada);
    end
  endtask

  task automatic test_bounce;
    int n;
    int bad;
    logic [3:0] fases [5];
    fases[0] = 4'b0001; fases[1] = 4'b0000; fases[2] = 4'b0001;
    fases[3] = 4'b0000; fases[4] = 4'b0000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      botoes = fases[i];
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (tem_jogada !== 1'b0 || db_estado !== 2'd0) bad++;
      end
    end
    for (int j = 0; j < LAT; j++) begin
      tick(1);
      if (tem_jogada !== 1'b0 || db_estado !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL bounce_quiet got %0d disturbed cycles expected 0", bad);
    end
    botoes = 4'b0001;
    wait_strobe(20, n);
    checks++;
    if (n !== LAT || jogada !== 4'b0001) begin
      fails++;
      $display("FAIL bounce_accept got edges=%0d jogada=%b expected %0d and 0001", n, jogada, LAT);
    end
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
  endtask

  task automatic test_habilita_baixo;
    int n;
    int pulses;
    habilita = 1'b0;
    botoes = 4'b1000;
    wait_estado(2'd3, 20, n);
    checks++;
    if (n !== LAT || tem_jogada !== 1'b0) begin
      fails++;
      $display("FAIL block_enter got edges=%0d tem=%b expected %0d and 0", n, tem_jogada, LAT);
    end
    habilita = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (tem_jogada === 1'b1 || db_estado !== 2'd3) pulses++;
    end
    checks++;
    if (pulses !== 0 || jogada !== 4'b0001) begin
      fails++;
      $display("FAIL block_hold got bad=%0d jogada=%b expected 0 and 0001", pulses, jogada);
    end
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
    checks++;
    if (n !== LAT) begin
      fails++;
      $display("FAIL block_release got %0d edges expected %0d", n, LAT);
    end
    botoes = 4'b1000;
    wait_strobe(20, n);
    checks++;
    if (n !== LAT || jogada !== 4'b1000) begin
      fails++;
      $display("FAIL block_next got edges=%0d jogada=%b expected %0d and 1000", n, jogada, LAT);
    end
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
  endtask

  task automatic test_multiplo;
    int n;
    habilita = 1'b1;
    botoes = 4'b0110;
`ifdef REJEITA_MULTIPLO_EN
    wait_estado(2'd3, 20, n);
    checks++;
    if (n !== LAT || multiplo !== 1'b1 || tem_jogada !== 1'b0 || jogada !== 4'b1000) begin
      fails++;
      $display("FAIL multi_reject got edges=%0d mult=%b tem=%b jogada=%b expected %0d 1 0 1000",
               n, multiplo, tem_jogada, jogada, LAT);
    end
    tick(1);
    checks++;
    if (multiplo !== 1'b0) begin
      fails++;
      $display("FAIL multi_pulse got mult=%b expected 0", multiplo);
    end
`else
    wait_strobe(20, n);
    checks++;
    if (n !== LAT || jogada !== 4'b0010 || multiplo !== 1'b0) begin
      fails++;
      $display("FAIL multi_priority got edges=%0d jogada=%b mult=%b expected %0d 0010 0",
               n, jogada, multiplo, LAT);
    end
`endif
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
  endtask

  task automatic test_limpa;
    int n;
    habilita = 1'b1;
    botoes = 4'b0001;
    tick(LAT - 1);
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    checks++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0001) begin
      fails++;
      $display("FAIL limpa_load got tem=%b jogada=%b expected 1 and 0001", tem_jogada, jogada);
    end
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    checks++;
    if (jogada !== 4'b0000) begin
      fails++;
      $display("FAIL limpa_clear got jogada=%b expected 0000", jogada);
    end
  endtask

  task automatic test_reset_segura;
    int n;
    habilita = 1'b1;
    botoes = 4'b0100;
    wait_strobe(20, n);
    tick(2);
    checks++;
    if (db_estado !== 2'd2 || jogada !== 4'b0100) begin
      fails++;
      $display("FAIL rst_pre got est=%0d jogada=%b expected 2 and 0100", db_estado, jogada);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tem_jogada, jogada, multiplo, db_estado} !== 8'h00) begin
      fails++;
      $display("FAIL rst_async got tem=%b jogada=%b mult=%b est=%0d expected all zero",
               tem_jogada, jogada, multiplo, db_estado);
    end
    tick(2);
    reset_n = 1'b1;
    wait_strobe(20, n);
    checks++;
    if (n !== LAT || jogada !== 4'b0100) begin
      fails++;
      $display("FAIL rst_repress got edges=%0d jogada=%b expected %0d and 0100", n, jogada, LAT);
    end
    botoes = 4'b0000;
    wait_estado(2'd0, 20, n);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_habilita_baixo();
    test_multiplo();
    test_limpa();
    test_reset_segura();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
